// File: rtl/otter_loader_pkg.sv
// Shared types and constants for the serial program loader.
package otter_loader_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN    = 3'd1,
        DATA   = 3'd2,
        CKSUM  = 3'd3,
        FINISH = 3'd4,
        FAIL   = 3'd5
    } loader_state_e;

    // Byte receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Byte that opens a load session when seen while idle
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Clock cycles per serial bit, rounded to nearest
    function automatic int calc_clks_per_bit(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000 + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver with input synchronizer, start-bit glitch
// rejection and framing-error reporting.
module uart_rx
    import otter_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT + 1);

    logic [1:0]    sync_q;
    logic          rx_prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_s;
    logic          stop_tick;

    // Synchronized serial line
    assign rx_s = sync_q[1];

    // State register, synchronizer and bit-timing datapath flops
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            sync_q    <= {sync_q[0], RX};
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic: arm on falling edge, verify start at half bit,
    // then sample each following bit at its centre
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CW'(HALF_BIT - 1)) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // Line back high at mid start bit means it was a glitch
                    state_d   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: one-cycle result strobes at the stop-bit centre
    always_comb begin
        stop_tick = (state_q == RX_STOP) && (cnt_q == CW'(CLKS_PER_BIT - 1));
        rx_valid  = stop_tick && rx_s;
        frame_err = stop_tick && !rx_s;
        rx_byte   = shift_q;
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: receives a sync byte, a little-endian word count
// and the program words over UART, writes them to the memory programming
// port and holds the core in reset while loading.
// Optional feature: define LOADER_CKSUM_EN to require a trailing XOR
// checksum byte before the core is released.
module uart_prog_loader
    import otter_loader_pkg::*;
#(
    parameter int CLK_RATE   = 50,
    parameter int BAUD       = 115200,
    parameter int IB_TIMEOUT = 200
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RX,
    output logic        MCU_RST,
    output logic [31:0] RAM_ADDR,
    output logic [31:0] RAM_DATA,
    output logic        RAM_WE,
    output logic        BUSY,
    output logic        ERR
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_RATE, BAUD);
    localparam int TIMEOUT_CYC  = CLK_RATE * 1000 * IB_TIMEOUT;
    localparam int TO_W         = $clog2(TIMEOUT_CYC + 1);

`ifdef LOADER_CKSUM_EN
    localparam loader_state_e LOAD_DONE = CKSUM;
`else
    localparam loader_state_e LOAD_DONE = FINISH;
`endif

    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic            frame_err;

    loader_state_e   state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [23:0]     shift_q, shift_d;
    logic [31:0]     word_cnt_q, word_cnt_d;
    logic [31:0]     word_idx_q, word_idx_d;
    logic [31:0]     ram_addr_q, ram_addr_d;
    logic [31:0]     ram_data_q, ram_data_d;
    logic            ram_we_q, ram_we_d;
    logic            mcu_rst_q, mcu_rst_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] timeout_cnt_q, timeout_cnt_d;
`ifdef LOADER_CKSUM_EN
    logic [7:0]      cksum_q, cksum_d;
`endif

    logic [31:0]     word_next;
    logic            last_byte;
    logic            in_load;
    logic            timeout_hit;
    logic            load_abort;
    logic            sync_seen;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLK      (CLK),
        .RST      (RST),
        .RX       (RX),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    // Shared decode of the receive stream and error conditions
    always_comb begin
        word_next   = {rx_byte, shift_q};
        last_byte   = rx_valid && (byte_cnt_q == 2'd3);
        in_load     = (state_q == LEN) || (state_q == DATA) || (state_q == CKSUM);
        timeout_hit = (timeout_cnt_q == TO_W'(TIMEOUT_CYC));
        load_abort  = in_load && (frame_err || timeout_hit);
        sync_seen   = rx_valid && (rx_byte == SYNC_BYTE);
    end

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            byte_cnt_q    <= '0;
            shift_q       <= '0;
            word_cnt_q    <= '0;
            word_idx_q    <= '0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            ram_we_q      <= 1'b0;
            mcu_rst_q     <= 1'b0;
            err_q         <= 1'b0;
            timeout_cnt_q <= '0;
`ifdef LOADER_CKSUM_EN
            cksum_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            word_cnt_q    <= word_cnt_d;
            word_idx_q    <= word_idx_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            ram_we_q      <= ram_we_d;
            mcu_rst_q     <= mcu_rst_d;
            err_q         <= err_d;
            timeout_cnt_q <= timeout_cnt_d;
`ifdef LOADER_CKSUM_EN
            cksum_q       <= cksum_d;
`endif
        end
    end

    // Next-state logic of the load sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sync_seen) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (load_abort) begin
                    state_d = FAIL;
                end else if (last_byte) begin
                    state_d = (word_next == 32'd0) ? LOAD_DONE : DATA;
                end
            end
            DATA: begin
                if (load_abort) begin
                    state_d = FAIL;
                end else if (last_byte && ((word_idx_q + 32'd1) == word_cnt_q)) begin
                    state_d = LOAD_DONE;
                end
            end
`ifdef LOADER_CKSUM_EN
            CKSUM: begin
                if (load_abort) begin
                    state_d = FAIL;
                end else if (rx_valid) begin
                    state_d = (rx_byte == cksum_q) ? FINISH : FAIL;
                end
            end
`endif
            FINISH:  state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: byte assembly, word writes, core reset and error flag
    always_comb begin
        byte_cnt_d    = byte_cnt_q;
        shift_d       = shift_q;
        word_cnt_d    = word_cnt_q;
        word_idx_d    = word_idx_q;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        ram_we_d      = 1'b0;
        mcu_rst_d     = mcu_rst_q;
        err_d         = err_q;
        timeout_cnt_d = '0;
`ifdef LOADER_CKSUM_EN
        cksum_d       = cksum_q;
`endif
        // Inter-byte timer only runs while a load is open
        if (in_load && !rx_valid) begin
            timeout_cnt_d = timeout_cnt_q + TO_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (sync_seen) begin
                    err_d      = 1'b0;
                    mcu_rst_d  = 1'b1;
                    byte_cnt_d = '0;
                    shift_d    = '0;
                    word_cnt_d = '0;
                    word_idx_d = '0;
`ifdef LOADER_CKSUM_EN
                    cksum_d    = '0;
`endif
                end
            end
            LEN: begin
                if (!load_abort && rx_valid) begin
                    shift_d    = word_next[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte) begin
                        word_cnt_d = word_next;
                    end
                end
            end
            DATA: begin
                if (!load_abort && rx_valid) begin
                    shift_d    = word_next[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CKSUM_EN
                    cksum_d    = cksum_q ^ rx_byte;
`endif
                    if (last_byte) begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = {word_idx_q[29:0], 2'b00};
                        ram_data_d = word_next;
                        word_idx_d = word_idx_q + 32'd1;
                    end
                end
            end
            FINISH: mcu_rst_d = 1'b0;
            FAIL:   err_d     = 1'b1;
            default: begin
            end
        endcase
    end

    // Port outputs
    always_comb begin
        MCU_RST  = mcu_rst_q;
        RAM_ADDR = ram_addr_q;
        RAM_DATA = ram_data_q;
        RAM_WE   = ram_we_q;
        ERR      = err_q;
        BUSY     = (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed protocol cases plus
// randomized loads compared against a word-list reference model.
`timescale 1ns/1ps
module tb_uart_prog_loader;

    localparam int CLK_RATE   = 1;
    localparam int BAUD       = 100000;
    localparam int IB_TIMEOUT = 1;
    localparam int CPB        = 10;
    localparam int TO_CYC     = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        mcu_rst;
    logic [31:0] ram_addr;
    logic [31:0] ram_data;
    logic        ram_we;
    logic        busy;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] load_words[$];

    int   cyc = 0;
    int   we_cyc = 0;
    int   mrst_fall_cyc = 0;
    int   busy_fall_cyc = 0;
    logic mrst_prev = 1'b0;
    logic busy_prev = 1'b0;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLK_RATE  (CLK_RATE),
        .BAUD      (BAUD),
        .IB_TIMEOUT(IB_TIMEOUT)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .RX      (rx),
        .MCU_RST (mcu_rst),
        .RAM_ADDR(ram_addr),
        .RAM_DATA(ram_data),
        .RAM_WE  (ram_we),
        .BUSY    (busy),
        .ERR     (err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write strobe cycle and the falling edges of MCU_RST/BUSY
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            got_q.push_back({ram_addr, ram_data});
            we_cyc <= cyc;
        end
        if (mrst_prev && !mcu_rst) mrst_fall_cyc <= cyc;
        if (busy_prev && !busy)    busy_fall_cyc <= cyc;
        mrst_prev <= mcu_rst;
        busy_prev <= busy;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
        tick(3);
    endtask

    // Reference: a load of N words produces writes at 4*i of each word in order
    task automatic run_load();
        logic [31:0] n;
`ifdef LOADER_CKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        n = 32'(load_words.size());
        send_byte(8'hA5, 1'b1);
        chk("sync_mcu_rst", {63'd0, mcu_rst}, 64'd1);
        chk("sync_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b1);
        for (int i = 0; i < load_words.size(); i++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(load_words[i][8*b +: 8], 1'b1);
`ifdef LOADER_CKSUM_EN
                x = x ^ load_words[i][8*b +: 8];
`endif
            end
            exp_q.push_back({32'(i * 4), load_words[i]});
        end
`ifdef LOADER_CKSUM_EN
        send_byte(x, 1'b1);
`endif
    endtask

    // Empty load, used to bring the core back out of reset after a failure
    task automatic release_zero();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
`ifdef LOADER_CKSUM_EN
        send_byte(8'h00, 1'b1);
`endif
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk(tag, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_state(input string tag, input logic exp_mrst, input logic exp_err);
        chk({tag, "_mcu_rst"}, {63'd0, mcu_rst}, {63'd0, exp_mrst});
        chk({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int nn;
        int nw;

        rst = 1'b1;
        rx  = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(1);
        chk("rst_mcu_rst", {63'd0, mcu_rst}, 64'd0);
        chk("rst_ram_we", {63'd0, ram_we}, 64'd0);
        chk("rst_ram_addr", {32'd0, ram_addr}, 64'd0);
        chk("rst_ram_data", {32'd0, ram_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);

        // Bytes without sync are ignored
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        check_idle_state("nosync", 1'b0, 1'b0);
        check_writes("nosync_wr");

        // Two-word directed load
        load_words.delete();
        load_words.push_back(32'h0000_0013);
        load_words.push_back(32'h0010_0093);
        run_load();
        check_idle_state("two_word", 1'b0, 1'b0);
        check_writes("two_word_wr");
`ifndef LOADER_CKSUM_EN
        chk("two_word_release_lat", 64'(mrst_fall_cyc - we_cyc), 64'd1);
`endif
        chk("two_word_busy_fall", 64'(busy_fall_cyc), 64'(mrst_fall_cyc));

        // Zero-length load
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        chk("zero_mid_mcu_rst", {63'd0, mcu_rst}, 64'd1);
        send_byte(8'h00, 1'b1);
`ifdef LOADER_CKSUM_EN
        chk("zero_wait_ck_busy", {63'd0, busy}, 64'd1);
        send_byte(8'h00, 1'b1);
`endif
        check_idle_state("zero", 1'b0, 1'b0);
        check_writes("zero_wr");

        // Inter-byte timeout mid-word
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        tick(TO_CYC + 200);
        check_idle_state("timeout", 1'b1, 1'b1);
        check_writes("timeout_wr");
        send_byte(8'hA5, 1'b1);
        chk("resync_err", {63'd0, err}, 64'd0);
        chk("resync_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
`ifdef LOADER_CKSUM_EN
        send_byte(8'h00, 1'b1);
`endif
        check_idle_state("resync_done", 1'b0, 1'b0);

        // Framing error during DATA
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b0);
        tick(5);
        check_idle_state("frame", 1'b1, 1'b1);
        check_writes("frame_wr");
        release_zero();
        check_idle_state("frame_release", 1'b0, 1'b0);

`ifdef LOADER_CKSUM_EN
        // Checksum match and mismatch on a one-word load
        for (int k = 0; k < 2; k++) begin
            send_byte(8'hA5, 1'b1);
            send_byte(8'h01, 1'b1);
            for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
            send_byte(8'h13, 1'b1);
            for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
            send_byte((k == 0) ? 8'h13 : 8'h12, 1'b1);
            exp_q.push_back({32'h0, 32'h13});
            check_writes("ck_wr");
            if (k == 0) check_idle_state("ck_good", 1'b0, 1'b0);
            else        check_idle_state("ck_bad", 1'b1, 1'b1);
        end
        release_zero();
        check_idle_state("ck_release", 1'b0, 1'b0);
`endif

        // Reset mid-load: no partial write, outputs back to reset values
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h77, 1'b1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check_idle_state("midrst", 1'b0, 1'b0);
        send_byte(8'h77, 1'b1);
        check_writes("midrst_wr");
        chk("midrst_addr", {32'd0, ram_addr}, 64'd0);

        // Randomized loads with idle noise bytes before each sync
        for (int t = 0; t < 6; t++) begin
            nn = int'($urandom_range(0, 3));
            for (int i = 0; i < nn; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b, 1'b1);
            end
            load_words.delete();
            nw = int'($urandom_range(1, 4));
            for (int i = 0; i < nw; i++) load_words.push_back($urandom());
            run_load();
            check_idle_state("rand", 1'b0, 1'b0);
            check_writes("rand_wr");
`ifndef LOADER_CKSUM_EN
            chk("rand_release_lat", 64'(mrst_fall_cyc - we_cyc), 64'd1);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader upstream of the OTTER pipeline core. It receives a program image over a UART RX line and writes it word-by-word into the instruction/data memory's programming port. While loading it holds the core in reset, and it releases the core once the last word has been written. It sits between the board RX pin and the memory's programming write port (address, data and write enable, muxed in ahead of the data port) and the core's reset OR.

## Interface
- CLK_RATE, 50: clock frequency in MHz.
- BAUD, 115200: serial bit rate.
- IB_TIMEOUT, 200: inter-byte timeout in ms, measured while a load is in progress.
- CLK: input, 1 bit. System clock; all logic is on its rising edge.
- RST: input, 1 bit. Synchronous, active-high reset.
- RX: input, 1 bit. Asynchronous UART receive line, 8N1, idle high.
- MCU_RST: output, 1 bit. Held high while a load is in progress or after a failed load.
- RAM_ADDR: output, 32 bits. Byte address of the word being written.
- RAM_DATA: output, 32 bits. Word being written, little-endian assembled.
- RAM_WE: output, 1 bit. One-cycle write strobe for a full word.
- BUSY: output, 1 bit. High in any state other than IDLE.
- ERR: output, 1 bit. Sticky error flag; cleared by RST or by acceptance of a new sync byte.

## Operation
- Derived constants:
  - CLKS_PER_BIT = round(CLK_RATE*1e6/BAUD), which is 434 at the defaults.
  - TIMEOUT_CYC = CLK_RATE*1000*IB_TIMEOUT.
- Byte receiver:
  - RX passes through a 2-flop synchronizer.
  - A falling edge arms the receiver. The start bit is re-checked at CLKS_PER_BIT/2; if RX is high there, the event is a glitch and the receiver returns to idle.
  - 8 data bits are sampled LSB first at bit centres.
  - The stop bit is sampled at its centre. If it is 1, rx_valid pulses for one cycle with rx_byte. If it is 0 (framing error), no byte is produced and frame_err pulses.
- Loader FSM:
  - IDLE: bytes other than SYNC_BYTE = 0xA5 are ignored. On 0xA5: clear ERR, clear the byte and word counters, go to LEN.
  - LEN: collect 4 bytes little-endian into word_cnt[31:0].
    - word_cnt == 0: go to FINISH.
    - Otherwise: go to DATA.
  - DATA: collect 4 bytes little-endian into RAM_DATA. After the 4th byte:
    - Pulse RAM_WE with RAM_ADDR = {word_idx[29:0], 2'b00}.
    - Increment word_idx.
    - When word_idx reaches word_cnt, go to FINISH.
  - FINISH: deassert MCU_RST, then go to IDLE.
  - FAIL (one cycle): set ERR, keep MCU_RST high, go to IDLE.
- Error exits from LEN, DATA or CKSUM to FAIL:
  - The timeout counter reaches TIMEOUT_CYC. It resets on every rx_valid.
  - frame_err pulses.
- MCU_RST behaviour:
  - Set on sync acceptance.
  - Cleared only by FINISH or RST.
  - Reset value 0, so the existing image runs after power-up.
- A 0xA5 byte received mid-load is treated as data, never as a resync.
- Address arithmetic is modulo 2^32; word_cnt is not range-checked.

## Timing
- Reset values:
  - MCU_RST = 0, RAM_WE = 0, RAM_ADDR = 0, RAM_DATA = 0, BUSY = 0, ERR = 0.
  - FSM in IDLE, receiver idle.
- Byte latency: rx_valid is asserted CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the synchronized start edge, ±1 cycle.
- MCU_RST and BUSY rise in the cycle after rx_valid of the sync byte.
- RAM_WE is high for exactly the cycle after rx_valid of the 4th byte of each word. RAM_ADDR and RAM_DATA are stable in that cycle and hold until the next write.
- MCU_RST falls in the cycle after the final RAM_WE, or the cycle after the checksum is accepted when checksumming is enabled. BUSY falls in the same cycle.
- RST asserted mid-load: the load is aborted immediately and all outputs return to reset values; no partial write strobe is issued.

## Configuration
- `LOADER_CKSUM_EN` defined:
  - After the last DATA word (or after LEN when word_cnt == 0), the FSM enters CKSUM.
  - It receives one byte equal to the XOR of all data bytes.
  - Match: go to FINISH.
  - Mismatch: go to FAIL. Words already written remain in memory.
- Not defined: CKSUM and its XOR accumulator are absent; DATA or LEN goes directly to FINISH.

## Structure
- Package otter_loader_pkg holds:
  - The loader state enum: IDLE, LEN, DATA, CKSUM, FINISH, FAIL.
  - SYNC_BYTE.
  - The receiver state enum.
- Sub-module uart_rx:
  - Parameter CLKS_PER_BIT.
  - Ports CLK, RST, RX, rx_byte[7:0], rx_valid, frame_err.
  - Contains the synchronizer.
- Top level: FSM, byte/word counters, little-endian shift register, timeout counter, optional XOR accumulator.

## Test plan
- Reset → all outputs 0. Stream bytes 0x00, 0x13 without a sync byte → no RAM_WE, MCU_RST stays 0.
- Send A5, 02 00 00 00, 13 00 00 00, 93 00 10 00 → RAM_WE at addr 0x0 data 0x00000013, then at addr 0x4 data 0x00100093. MCU_RST is high from sync until the cycle after the 2nd write.
- Send A5, 00 00 00 00 → no RAM_WE; MCU_RST pulses high then falls. With the checksum enabled, a checksum byte 00 is required.
- Send A5, 01 00 00 00, 13 00, then idle for more than TIMEOUT_CYC (use IB_TIMEOUT scaled down in the bench) → no write, ERR = 1, MCU_RST = 1. Then send A5 → ERR clears.
- Send a byte with stop bit 0 during DATA → FAIL, ERR = 1.
- With `LOADER_CKSUM_EN`: a one-word load of 13 00 00 00 with checksum 13 → release. The same load with checksum 12 → ERR = 1 and MCU_RST stays 1.
